inst_loader: RTL and testbench

// - Boot-time writer for the instruction memory: consumes a byte stream (valid/ready), assembles
//   big-endian 32-bit instructions, writes them sequentially into inst RAM.
// - Holds the CPU core in reset (cpu_rst_o) until the image is loaded; sits between the serial

---
 rtl/inst_loader_pkg.sv | 6 +
 rtl/inst_loader.sv | 104 ++++++++++
 tb/tb_inst_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared address/instruction types and loader state encoding
package inst_loader_pkg;
    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR} loader_state_t;
endpackage

// File: rtl/inst_loader.sv
// inst_loader: byte stream -> big-endian words -> inst RAM, holds CPU in reset until loaded; LOADER_CHECKSUM_EN adds a trailing XOR byte
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int         DEPTH     = 1024,
    parameter inst_addr_t BASE_ADDR = 32'h0,
    parameter int         TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        ram_we,
    output inst_addr_t  ram_addr,
    output inst_t       ram_wdata,
    output logic        cpu_rst_o,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t FIN = CHK;
    logic [7:0] sum;
`else
    localparam loader_state_t FIN = DONE;
`endif
    loader_state_t state, state_n;
    logic [15:0] len;
    logic [15:0] hdr;
    logic [1:0] nbyte;
    logic [TW-1:0] idle;
    logic acc, begin_load, timed_out;
    assign rx_ready   = state inside {LEN_HI, LEN_LO, DATA, CHK};
    assign acc        = rx_valid && rx_ready;
    assign begin_load = start && state inside {IDLE, DONE, ERR};
    assign timed_out  = rx_ready && !acc && idle == TW'(TIMEOUT - 1);
    assign hdr        = {len[15:8], rx_data};
    assign ram_we     = state == WRITE;
    assign done       = state == DONE;
    assign error      = state == ERR;
    assign cpu_rst_o  = state != DONE;
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (begin_load) state_n = LEN_HI;
            LEN_HI:          if (acc) state_n = LEN_LO;
            LEN_LO:          if (acc) state_n = hdr == 16'd0 ? FIN : {16'd0, hdr} > 32'(DEPTH) ? ERR : DATA;
            DATA:            if (acc && nbyte == 2'd3) state_n = WRITE;
            WRITE:           state_n = words_loaded + 16'd1 < len ? DATA : FIN;
`ifdef LOADER_CHECKSUM_EN
            CHK:             if (acc) state_n = rx_data == sum ? DONE : ERR;
`endif
            default:         state_n = IDLE;
        endcase
        if (timed_out)
            state_n = ERR;
    end
    // ram_addr is latched when a word completes so it never runs past the last written word
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr     <= BASE_ADDR;
            ram_wdata    <= '0;
            words_loaded <= '0;
            len          <= '0;
            nbyte        <= '0;
            idle         <= '0;
        end else if (begin_load) begin
            words_loaded <= '0;
            nbyte        <= '0;
            idle         <= '0;
        end else begin
            idle <= acc ? '0 : rx_ready ? idle + 1'b1 : idle;
            if (acc && state == LEN_HI)
                len[15:8] <= rx_data;
            if (acc && state == LEN_LO)
                len[7:0] <= rx_data;
            if (acc && state == DATA) begin
                ram_wdata <= {ram_wdata[23:0], rx_data};
                nbyte     <= nbyte + 2'd1;
                if (nbyte == 2'd3)
                    ram_addr <= BASE_ADDR + inst_addr_t'({words_loaded, 2'b00});
            end
            if (state == WRITE)
                words_loaded <= words_loaded + 16'd1;
        end
    end
`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || begin_load)
            sum <= '0;
        else if (acc && state != CHK)
            sum <= sum ^ rx_data;
    end
`endif
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table-driven frames plus hand sequences; RAM writes checked against a scoreboard queue
module tb_inst_loader;
    localparam int DEPTH = 1024;
    localparam logic [31:0] BASE = 32'h0;
    localparam int TMO = 40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ready, ram_we, cpu_rst_o, done, error;
    logic [31:0] ram_addr, ram_wdata;
    logic [15:0] words_loaded;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    typedef struct packed {
        logic [15:0] n;
        logic [95:0] data;
        logic        gaps;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
    } vec_t;
    vec_t vecs[6];
    always #5 clk = ~clk;
    inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_rst_o(cpu_rst_o), .done(done), .error(error), .words_loaded(words_loaded)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wdata);
            end else
                chk("ram_write", {ram_addr, ram_wdata}, exp_q.pop_front());
        end
    end
    function automatic int gap(input logic g);
        return g ? int'($urandom_range(0, TMO / 2)) : 0;
    endfunction
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input int g);
        repeat (g) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                return;
            end
        end
        chk("rx_ready_wait", 64'(rx_ready), 64'(1));
        rx_valid = 1'b0;
    endtask
    task automatic send_word(input logic [31:0] w, input logic g);
        for (int b = 0; b < 4; b++)
            send_byte(w[31-8*b -: 8], gap(g));
    endtask
`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] frame_xor(input vec_t v);
        logic [7:0] s;
        logic [31:0] w;
        s = v.n[15:8] ^ v.n[7:0];
        for (int i = 0; i < int'(v.n); i++) begin
            w = v.data[95-32*i -: 32];
            s = s ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        return s;
    endfunction
`endif
    task automatic send_frame(input vec_t v);
        logic [31:0] w;
        pulse_start();
        send_byte(v.n[15:8], 0);
        send_byte(v.n[7:0], gap(v.gaps));
        if (int'(v.n) <= DEPTH) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = v.data[95-32*i -: 32];
                exp_q.push_back({BASE + 32'(4 * i), w});
                send_word(w, v.gaps);
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(frame_xor(v), gap(v.gaps));
`endif
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'(0));
        chk({tag, "_ram_we"}, 64'(ram_we), 64'(0));
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(BASE));
        chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'(0));
        chk({tag, "_cpu_rst"}, 64'(cpu_rst_o), 64'(1));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_error"}, 64'(error), 64'(0));
        chk({tag, "_words"}, 64'(words_loaded), 64'(0));
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{16'd2,    96'h12345678_ABCDEF01_00000000, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{16'd0,    96'h0,                          1'b0, 1'b1, 1'b0, 16'd0};
        vecs[2] = '{16'h0401, 96'h0,                          1'b0, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{16'd3,    96'hDEADBEEF_00000000_FFFFFFFF, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[4] = '{16'd2,    96'h12345678_ABCDEF01_00000000, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[5] = '{16'd1,    96'hA5A5A5A5_00000000_00000000, 1'b0, 1'b1, 1'b0, 16'd1};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i]);
            if (vecs[i].n == 16'd0)
                chk($sformatf("v%0d_zero_len_done_now", i), 64'(done), 64'(1));
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
            chk($sformatf("v%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_cpu_rst", i), 64'(cpu_rst_o), 64'(!vecs[i].exp_done));
            chk($sformatf("v%0d_words", i), 64'(words_loaded), 64'(vecs[i].exp_words));
        end
        // mid-word timeout, with a stray start that must be ignored
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({BASE, 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 1'b0);
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("stray_start_words", 64'(words_loaded), 64'(1));
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("timeout_minus1_error", 64'(error), 64'(0));
        @(posedge clk);
        #1;
        chk("timeout_error", 64'(error), 64'(1));
        chk("timeout_cpu_rst", 64'(cpu_rst_o), 64'(1));
        chk("timeout_words", 64'(words_loaded), 64'(1));
        // reset in the middle of a data word
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midload_rst");
        rst = 1'b0;
        send_frame(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("after_rst_done", 64'(done), 64'(1));
        chk("after_rst_words", 64'(words_loaded), 64'(2));
`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            send_byte(8'h00, 0);
            send_byte(8'h01, 0);
            exp_q.push_back({BASE, 32'h11223344});
            send_word(32'h11223344, 1'b0);
            send_byte(k == 0 ? 8'h45 : 8'h00, 0);
            #1;
            chk($sformatf("csum%0d_done", k), 64'(done), 64'(k == 0));
            chk($sformatf("csum%0d_error", k), 64'(error), 64'(k != 0));
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
